// File: rtl/led_pwm_ctrl_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Register map and byte-lane write helper for led_pwm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam logic [2:0] LED_REG_CTRL      = 3'd0;
    localparam logic [2:0] LED_REG_ON        = 3'd1;
    localparam logic [2:0] LED_REG_BLINK_EN  = 3'd2;
    localparam logic [2:0] LED_REG_BLINK_PER = 3'd3;
    localparam logic [2:0] LED_REG_DUTY      = 3'd4;

    // Replace the bytes of old_val whose select bit is set with those of new_val.
    function automatic logic [31:0] wb_byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] v;
        v = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                v[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_gen.sv
// ============================================================================
// Module      : led_pwm_gen
// Description : Free-running PWM counter with duty shadow reloaded at wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_on
);

    localparam logic [PWM_BITS-1:0] C_CNT_MAX = '1;

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty_act;

    // Duty is only sampled at the wrap edge so a period is never cut short.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_duty_act <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_CNT_MAX) begin
                r_duty_act <= i_duty;
            end
        end
    end

    assign o_pwm_on = (r_duty_act == C_CNT_MAX) | (r_cnt < r_duty_act);

endmodule

`default_nettype wire

// File: rtl/led_pwm_ctrl.sv
// ============================================================================
// Module      : led_pwm_ctrl
// Description : Wishbone LED controller with static, blink and PWM control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_ctrl
    import led_pkg::*;
#(
    parameter int N_LEDS   = 16,
    parameter int PWM_BITS = 8,
    parameter int BLINK_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_cycle,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [2:0]        i_wb_addr,
    input  logic [3:0]        i_wb_sel,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_data,
    output logic [N_LEDS-1:0] o_led_data
);

    logic                r_ctrl_en;
    logic [N_LEDS-1:0]   r_led_on;
    logic [N_LEDS-1:0]   r_blink_en;
    logic [BLINK_W-1:0]  r_blink_per;
    logic [PWM_BITS-1:0] r_duty;
    logic [BLINK_W-1:0]  r_bcnt;
    logic                r_phase;
    logic                r_ack;
    logic [31:0]         r_rdata;
    logic [N_LEDS-1:0]   r_led;

    logic        w_accept;
    logic        w_write;
    logic        w_wr_per;
    logic [31:0] w_rd_val;
    logic [31:0] w_mrg_ctrl;
    logic [31:0] w_mrg_on;
    logic [31:0] w_mrg_ben;
    logic [31:0] w_mrg_per;
    logic [31:0] w_mrg_duty;
    logic        w_pwm_on;
    logic        w_unused;

    assign w_accept = i_wb_cycle & i_wb_stb;
    assign w_write  = w_accept & i_wb_we;
    assign w_wr_per = w_write & (i_wb_addr == LED_REG_BLINK_PER);

    assign w_mrg_ctrl = wb_byte_merge(32'(r_ctrl_en),   i_wb_data, i_wb_sel);
    assign w_mrg_on   = wb_byte_merge(32'(r_led_on),    i_wb_data, i_wb_sel);
    assign w_mrg_ben  = wb_byte_merge(32'(r_blink_en),  i_wb_data, i_wb_sel);
    assign w_mrg_per  = wb_byte_merge(32'(r_blink_per), i_wb_data, i_wb_sel);
    assign w_mrg_duty = wb_byte_merge(32'(r_duty),      i_wb_data, i_wb_sel);

    // Bits above each register's width are discarded by design.
    assign w_unused = ^{w_mrg_ctrl, w_mrg_on, w_mrg_ben, w_mrg_per, w_mrg_duty};

    always_comb begin
        w_rd_val = '0;
        case (i_wb_addr)
            LED_REG_CTRL:      w_rd_val = 32'(r_ctrl_en);
            LED_REG_ON:        w_rd_val = 32'(r_led_on);
            LED_REG_BLINK_EN:  w_rd_val = 32'(r_blink_en);
            LED_REG_BLINK_PER: w_rd_val = 32'(r_blink_per);
            LED_REG_DUTY:      w_rd_val = 32'(r_duty);
            default:           w_rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl_en   <= 1'b0;
            r_led_on    <= '0;
            r_blink_en  <= '0;
            r_blink_per <= '0;
            r_duty      <= '0;
        end else if (w_write) begin
            case (i_wb_addr)
                LED_REG_CTRL:      r_ctrl_en   <= w_mrg_ctrl[0];
                LED_REG_ON:        r_led_on    <= w_mrg_on[N_LEDS-1:0];
                LED_REG_BLINK_EN:  r_blink_en  <= w_mrg_ben[N_LEDS-1:0];
                LED_REG_BLINK_PER: r_blink_per <= w_mrg_per[BLINK_W-1:0];
                LED_REG_DUTY:      r_duty      <= w_mrg_duty[PWM_BITS-1:0];
                default:           ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // A period rewrite restarts the blink cycle and overrides a coincident terminal count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_wr_per) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (r_bcnt == r_blink_per) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_duty   (r_duty),
        .o_pwm_on (w_pwm_on)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_led <= '0;
        end else begin
            r_led <= {N_LEDS{r_ctrl_en & w_pwm_on}} & r_led_on
                   & (~r_blink_en | {N_LEDS{r_phase}});
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_led_data = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
// ============================================================================
// Module      : tb_led_pwm_ctrl
// Description : Randomized bench for led_pwm_ctrl against a timing-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pwm_ctrl;

    localparam int N  = 16;
    localparam int PW = 8;
    localparam int BW = 24;
    localparam int PERIOD = 1 << PW;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_wb_cycle, i_wb_stb, i_wb_we;
    logic [2:0]    i_wb_addr;
    logic [3:0]    i_wb_sel;
    logic [31:0]   i_wb_data;
    logic          o_wb_stall, o_wb_ack;
    logic [31:0]   o_wb_data;
    logic [N-1:0]  o_led_data;

    led_pwm_ctrl #(.N_LEDS(N), .PWM_BITS(PW), .BLINK_W(BW)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_cycle (i_wb_cycle),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_sel   (i_wb_sel),
        .i_wb_data  (i_wb_data),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_led_data (o_led_data)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: register contents, edges since reset, edge of last blink restart.
    logic [31:0] m_ctrl, m_on, m_ben, m_per, m_duty;
    int unsigned m_t, m_restart, m_duty_act;
    logic        e_ack, e_rd;
    logic [31:0] e_rdata, e_led;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_on = 0; m_ben = 0; m_per = 0; m_duty = 0;
        m_t = 0; m_restart = 0; m_duty_act = 0;
        e_ack = 0; e_rd = 0; e_rdata = 0; e_led = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_ctrl;
            3'd1:    return m_on;
            3'd2:    return m_ben;
            3'd3:    return m_per;
            3'd4:    return m_duty;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] sel, input logic [31:0] mask);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
        return v & mask;
    endfunction

    // One clock edge of the reference behaviour, evaluated from pre-edge state.
    task automatic model_edge(input logic acc, input logic we, input logic [2:0] a,
                              input logic [3:0] sel, input logic [31:0] d);
        int unsigned cnt, k;
        bit phase, pwm;
        cnt   = m_t % PERIOD;
        k     = m_t - m_restart;
        phase = ((k / (m_per + 1)) % 2) == 0;
        pwm   = (m_duty_act == PERIOD - 1) || (cnt < m_duty_act);
        e_led = 0;
        for (int i = 0; i < N; i++)
            e_led[i] = m_ctrl[0] && m_on[i] && pwm && (m_ben[i] ? phase : 1'b1);
        e_ack = acc;
        e_rd  = acc && !we;
        if (acc) e_rdata = model_read(a);
        if (cnt == PERIOD - 1) m_duty_act = m_duty;
        if (acc && we) begin
            case (a)
                3'd0: m_ctrl = merge(m_ctrl, d, sel, 32'h1);
                3'd1: m_on   = merge(m_on,   d, sel, (32'h1 << N) - 1);
                3'd2: m_ben  = merge(m_ben,  d, sel, (32'h1 << N) - 1);
                3'd3: begin
                    m_per     = merge(m_per, d, sel, (32'h1 << BW) - 1);
                    m_restart = m_t + 1;
                end
                3'd4: m_duty = merge(m_duty, d, sel, PERIOD - 1);
                default: ;
            endcase
        end
        m_t++;
    endtask

    task automatic step(input logic cyc, input logic stb, input logic we, input logic [2:0] a,
                        input logic [3:0] sel, input logic [31:0] d);
        i_wb_cycle = cyc; i_wb_stb = stb; i_wb_we = we;
        i_wb_addr = a; i_wb_sel = sel; i_wb_data = d;
        model_edge(cyc & stb, we, a, sel, d);
        @(negedge i_clk);
        check_val("ack", 32'(o_wb_ack), 32'(e_ack));
        check_val("stall", 32'(o_wb_stall), 32'h0);
        check_val("led", 32'(o_led_data), e_led);
        if (e_rd) check_val("rdata", o_wb_data, e_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b1, a, 4'hF, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, 1'b0, a, 4'hF, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_led"},   32'(o_led_data), 32'h0);
        check_val({tag, "_ack"},   32'(o_wb_ack),   32'h0);
        check_val({tag, "_rdata"}, o_wb_data,       32'h0);
        check_val({tag, "_stall"}, 32'(o_wb_stall), 32'h0);
    endtask

    task automatic async_reset();
        #2 i_reset = 1'b1;
        i_wb_cycle = 0; i_wb_stb = 0; i_wb_we = 0;
        #1 check_reset_outputs("async_rst");
        @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
        check_reset_outputs("post_rst");
    endtask

    task automatic random_traffic(input int n);
        int r;
        logic [2:0]  a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom), 3'($urandom), 4'($urandom), $urandom);
            end else begin
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                if (a == 3'd3) d = $urandom_range(0, 9);
                if (a == 3'd4 && r < 70) d = (r < 57) ? 32'h0 : 32'hFF;
                if (a == 3'd0 && r < 80) d = 32'h1;
                step(1'b1, 1'b1, 1'($urandom), a, 4'($urandom_range(0, 15)), d);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_wb_cycle = 0; i_wb_stb = 0; i_wb_we = 0;
        i_wb_addr = 0; i_wb_sel = 0; i_wb_data = 0;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        check_reset_outputs("reset");
        for (int a = 0; a < 8; a++) rd(3'(a));

        // Static enable with full duty; output follows once the duty shadow reloads.
        wr(3'd0, 32'h1);
        wr(3'd4, 32'hFF);
        wr(3'd1, 32'h00A5);
        idle(PERIOD + 4);
        check_val("led_static", 32'(o_led_data), 32'h00A5);
        rd(3'd1);
        check_val("rb_led_on", o_wb_data, 32'h00A5);

        // Quarter duty, then a mid-period change that must wait for the wrap.
        wr(3'd4, 32'h40);
        wr(3'd1, 32'h1);
        idle(PERIOD + 2);
        for (int i = 0; i < 2 * PERIOD && (m_t % PERIOD) != 10; i++) idle(1);
        wr(3'd4, 32'h80);
        idle(2 * PERIOD + 4);

        // Blink with full duty, and a period rewrite on the terminal-count cycle.
        wr(3'd4, 32'hFF);
        idle(PERIOD + 2);
        wr(3'd2, 32'h1);
        wr(3'd3, 32'h3);
        idle(13);
        for (int i = 0; i < 8 && ((m_t - m_restart) % (m_per + 1)) != m_per; i++) idle(1);
        wr(3'd3, 32'h3);
        idle(12);
        wr(3'd3, 32'h0);
        idle(6);

        // Back-to-back pipelined strobes with a partial byte-lane write.
        step(1'b1, 1'b1, 1'b1, 3'd1, 4'b0001, 32'hFFFF);
        rd(3'd1);
        check_val("bb_low_byte", o_wb_data, 32'h00FF);
        rd(3'd6);
        check_val("bb_unmapped", o_wb_data, 32'h0);
        idle(2);

        random_traffic(2500);
        wr(3'd3, 32'h5);
        idle(3);
        async_reset();
        for (int a = 0; a < 8; a++) rd(3'(a));
        random_traffic(2500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
